dmem_bridge: RTL and testbench
==============================

Name: dmem_bridge

Overview:
- Data-side memory bridge between the CPU's memory-stage port (address, write data, write enable, read data) and an external handshaked data RAM/bus with variable latency.
- Converts each load/store into one bus transaction, generates byte enables, and aligns and extends load data.
- Holds the pipeline with a stall output until the transaction completes.
- Sits directly downstream of the cpu core's M stage, in the SoC top next to the instruction memory.

Parameters:
- ADDR_W, 32, byte address width on both sides.
- TIMEOUT, 255, max cycles spent waiting for mem_ready before a bus error is declared; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- memreadM  in  1  load in M stage
- memwriteM  in  1  store in M stage
- sizeM  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
- signedM  in  1  sign-extend loaded byte/half when 1
- aluoutM  in  ADDR_W  effective byte address
- writedataM  in  32  store data, right-justified
- readdataM  out  32  aligned/extended load result
- stallM  out  1  hold pipeline (M and earlier) while 1
- addr_err  out  1  one-cycle pulse: misaligned access
- bus_err  out  1  one-cycle pulse: timeout
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  bus completion, sampled on clk
- mem_rdata  in  32  bus read data, valid when mem_ready=1

Behaviour:
- Reset (rst=0, async): state IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, readdataM, counter = 0; addr_err, bus_err = 0. stallM = 0 in IDLE with no request.
- req = memreadM | memwriteM. If both are 1, treat the access as a store.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - In IDLE with req and misaligned: addr_err=1 for that cycle (combinational), stallM=0, no bus access, readdataM driven 0.
- FSM states: IDLE, REQ, DONE.
- IDLE, aligned req: stallM=1 combinationally that same cycle. Latch we, mem_addr={addr[ADDR_W-1:2],2'b00}, mem_be, mem_wdata, size, signed, addr[1:0]. Go to REQ; mem_req=1 from the next cycle.
- mem_be: byte = 1<<addr[1:0]; half = 0011 or 1100 by addr[1]; word = 1111.
- mem_wdata: byte replicated x4, half replicated x2, word as-is.
- REQ: stallM=1; mem_req and all bus outputs held stable; counter increments each cycle.
  - On mem_ready=1: for a load, shift mem_rdata by latched addr[1:0]*8, mask to size, sign/zero extend, register into readdataM. Go to DONE. Counter cleared.
  - If counter reaches TIMEOUT with mem_ready=0: bus_err pulses 1 cycle, readdataM=0, go to DONE.
  - mem_ready outside REQ is ignored.
- DONE: stallM=0, mem_req=0, readdataM held. The pipeline advances at the end of this cycle; next state is IDLE. Completion latency = 3 cycles for mem_ready in the first REQ cycle.
- A new req seen in IDLE the cycle after DONE is a new access.
- Stores leave readdataM unchanged.
- Reset mid-transaction aborts immediately: mem_req drops asynchronously and no completion is reported.

Decomposition:
- Shared package cpu_defs: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state encoding.
- Sub-module load_align (combinational): mem_rdata, offset, size, signed -> 32-bit result. It is reused later by the instruction-side cache refill path.

Test Plan:
- Word store, addr 0x0000_0104, data 0xDEADBEEF, mem_ready after 2 REQ cycles -> mem_addr 0x104, mem_be 1111, mem_we 1, stallM high 3 cycles, low in DONE.
- Byte load signed at addr 0x203, mem_rdata 0x80FF_1234 -> readdataM 0xFFFF_FF80; same with signedM=0 -> 0x0000_0080; mem_be 1000.
- Half store at addr 0x2, data 0x0000_ABCD -> mem_be 1100, mem_wdata 0xABCD_ABCD; half load unsigned there with mem_rdata 0x5678_0000 -> 0x0000_5678.
- Word load at addr 0x6 -> addr_err one-cycle pulse, stallM 0, mem_req never asserted.
- mem_ready held 0 -> bus_err pulses after TIMEOUT REQ cycles, readdataM 0, FSM returns to IDLE.
- rst low while in REQ -> mem_req 0 immediately, state IDLE; a subsequent load completes normally.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared CPU data-side definitions: access sizes, bridge FSM states and
// lane helpers used by the data memory bridge.
package cpu_defs;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic [3:0] byte_en(size_t sz, logic [1:0] off);
    case (sz)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data is right-justified; replicate it into every lane it may land in.
  function automatic logic [31:0] lane_wdata(size_t sz, logic [31:0] d);
    case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic misaligned(size_t sz, logic [1:0] off);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Handshaked data RAM/bus port between the memory bridge (master) and the
// external data memory (slave).
interface dmem_bridge_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/dmem_bridge_load_align.sv
// Combinational load aligner: extracts the addressed byte/half/word from a
// 32-bit bus word and sign- or zero-extends it.
module load_align
  import cpu_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  size_t       size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (size)
      SZ_BYTE: result = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: result = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Data-side memory bridge: turns M-stage loads/stores into single handshaked
// bus transactions, stalling the pipeline until each one completes.
module dmem_bridge
  import cpu_defs::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memreadM,
  input  logic              memwriteM,
  input  logic [1:0]        sizeM,
  input  logic              signedM,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [31:0]       writedataM,
  output logic [31:0]       readdataM,
  output logic              stallM,
  output logic              addr_err,
  output logic              bus_err,
  dmem_bridge_if.master     bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic              req, mis, timeout;
  size_t             sz;
  logic              req_q, we_q, sign_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q, rdata_q, aligned;
  size_t             size_q;
  logic [1:0]        off_q;
  logic [CW-1:0]     cnt_q;

  assign req = memreadM | memwriteM;
  assign sz  = size_t'(sizeM);
  assign mis = misaligned(sz, aluoutM[1:0]);

  load_align u_align (
    .rdata    (bus.mem_rdata),
    .offset   (off_q),
    .size     (size_q),
    .sign_ext (sign_q),
    .result   (aligned)
  );

  always_comb begin
    state_d  = state_q;
    stallM   = 1'b0;
    addr_err = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        if (mis) begin
          addr_err = 1'b1;
        end else begin
          stallM  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stallM = 1'b1;
        if (bus.mem_ready) begin
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          timeout = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus_err = timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
      sign_q  <= 1'b0;
      off_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (req) begin
          if (mis) begin
            rdata_q <= '0;
          end else begin
            req_q   <= 1'b1;
            we_q    <= memwriteM;
            addr_q  <= {aluoutM[ADDR_W-1:2], 2'b00};
            be_q    <= byte_en(sz, aluoutM[1:0]);
            wdata_q <= lane_wdata(sz, writedataM);
            size_q  <= sz;
            sign_q  <= signedM;
            off_q   <= aluoutM[1:0];
            cnt_q   <= '0;
          end
        end
        REQ: begin
          if (bus.mem_ready) begin
            req_q <= 1'b0;
            cnt_q <= '0;
            if (!we_q) rdata_q <= aligned;
          end else if (timeout) begin
            req_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // A rejected misaligned access must not expose stale load data that cycle.
  assign readdataM     = addr_err ? '0 : rdata_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: directed scenarios plus random loads/stores
// against a variable-latency bus responder and a behavioural memory model.
module tb_dmem_bridge;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memreadM = 1'b0, memwriteM = 1'b0, signedM = 1'b0;
  logic [1:0]  sizeM = 2'b00;
  logic [31:0] aluoutM = '0, writedataM = '0;
  logic [31:0] readdataM;
  logic        stallM, addr_err, bus_err;

  dmem_bridge_if #(.ADDR_W(32)) bif ();

  dmem_bridge #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .memreadM   (memreadM),
    .memwriteM  (memwriteM),
    .sizeM      (sizeM),
    .signedM    (signedM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .addr_err   (addr_err),
    .bus_err    (bus_err),
    .bus        (bif)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } bus_t;
  typedef struct { int kind; logic [31:0] rd; } res_t;   // kind: 0 ok, 1 addr_err, 2 timeout
  typedef struct { int lat; logic [31:0] rdata; } resp_t;

  bus_t  bus_q[$];
  res_t  res_q[$];
  resp_t resp_q[$];

  int          n_chk = 0, n_pass = 0;
  logic [31:0] model_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Bus responder: completes each request after its scheduled number of wait
  // cycles, and toggles noise on ready/rdata while no request is outstanding.
  initial begin : responder
    bit    active;
    int    waited;
    resp_t cur;
    active = 0;
    waited = 0;
    cur.lat = 1000;
    cur.rdata = '0;
    bif.mem_ready = 1'b0;
    bif.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bif.mem_ready = 1'b0;
      bif.mem_rdata = $urandom;
      if (bif.mem_req) begin
        if (!active) begin
          active = 1;
          waited = 0;
          if (resp_q.size() > 0) cur = resp_q.pop_front();
          else begin cur.lat = 1000; cur.rdata = '0; end
        end
        if (waited == cur.lat) begin
          bif.mem_ready = 1'b1;
          bif.mem_rdata = cur.rdata;
        end
        waited++;
      end else begin
        active = 0;
        bif.mem_ready = ($urandom % 4 == 0);
      end
    end
  end

  // Monitor: bus-side stability/contents and pipeline-side completions.
  bit prev_stall = 0, prev_req = 0;
  int berr_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 0;
      prev_req = 0;
      berr_cnt = 0;
    end else begin
      if (bif.mem_req) begin
        if (bus_q.size() == 0) chk("bus_unexpected_req", 32'(bif.mem_req), 32'd0);
        else begin
          chk("mem_addr", bif.mem_addr, bus_q[0].addr);
          chk("mem_be", 32'(bif.mem_be), 32'(bus_q[0].be));
          chk("mem_we", 32'(bif.mem_we), 32'(bus_q[0].we));
          if (bus_q[0].we) chk("mem_wdata", bif.mem_wdata, bus_q[0].wdata);
        end
      end
      if (prev_req && !bif.mem_req && bus_q.size() > 0) void'(bus_q.pop_front());
      if (bus_err) berr_cnt++;
      if (addr_err) begin
        chk("addr_err_readdata", readdataM, 32'd0);
        chk("addr_err_stall", 32'(stallM), 32'd0);
        chk("addr_err_no_req", 32'(bif.mem_req), 32'd0);
        if (res_q.size() == 0) chk("addr_err_unexpected", 32'd1, 32'd0);
        else chk("addr_err_kind", 32'd1, 32'(res_q.pop_front().kind));
      end
      if (prev_stall && !stallM) begin
        res_t r;
        int   got_kind;
        got_kind = (berr_cnt == 0) ? 0 : (berr_cnt == 1 ? 2 : 9);
        if (res_q.size() == 0) chk("completion_unexpected", 32'd1, 32'd0);
        else begin
          r = res_q.pop_front();
          chk("completion_kind", 32'(got_kind), 32'(r.kind));
          chk("readdataM", readdataM, r.rd);
        end
        berr_cnt = 0;
      end
      prev_stall = stallM;
      prev_req = bif.mem_req;
    end
  end

  task automatic access(input logic we, input logic rd, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic sg,
                        input int lat, input logic [31:0] rdat);
    logic [1:0]  off;
    bit          mis;
    bus_t        b;
    res_t        r;
    resp_t       p;
    logic [31:0] v;
    int          n, exp_n, sh;
    off = a[1:0];
    mis = (sz == 2'b01 && off[0]) || (sz[1] && off != 2'b00);
    exp_n = 0;
    if (mis) begin
      model_rd = '0;
      r.kind = 1;
      r.rd = '0;
      res_q.push_back(r);
    end else begin
      b.addr = a & ~32'h3;
      b.we = we;
      case (sz)
        2'b00: begin b.be = 4'(1 << off); b.wdata = {24'h0, wd[7:0]} * 32'h0101_0101; end
        2'b01: begin b.be = off[1] ? 4'hC : 4'h3; b.wdata = {16'h0, wd[15:0]} * 32'h0001_0001; end
        default: begin b.be = 4'hF; b.wdata = wd; end
      endcase
      bus_q.push_back(b);
      p.lat = lat;
      p.rdata = rdat;
      resp_q.push_back(p);
      if (lat > TO) begin
        r.kind = 2;
        model_rd = '0;
        exp_n = TO + 2;
      end else begin
        r.kind = 0;
        exp_n = lat + 2;
        if (!we) begin
          sh = 8 * int'(off);
          v = rdat >> sh;
          if (sz == 2'b00) begin
            v = v & 32'hFF;
            if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
          end else if (sz == 2'b01) begin
            v = v & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
          end
          model_rd = v;
        end
      end
      r.rd = model_rd;
      res_q.push_back(r);
    end
    memreadM = rd; memwriteM = we; sizeM = sz; signedM = sg; aluoutM = a; writedataM = wd;
    if (mis) begin
      @(posedge clk); #1;
    end else begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (stallM && n < TO + 20);
      chk("stall_cycles", 32'(n), 32'(exp_n));
      @(posedge clk); #1;
    end
    memreadM = 1'b0; memwriteM = 1'b0;
    sizeM = 2'($urandom); signedM = 1'($urandom); aluoutM = $urandom; writedataM = $urandom;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin : stim
    #1 rst = 1'b0;
    #2;
    chk("rst_mem_req", 32'(bif.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bif.mem_we), 32'd0);
    chk("rst_mem_be", 32'(bif.mem_be), 32'd0);
    chk("rst_mem_addr", bif.mem_addr, 32'd0);
    chk("rst_mem_wdata", bif.mem_wdata, 32'd0);
    chk("rst_readdataM", readdataM, 32'd0);
    chk("rst_stallM", 32'(stallM), 32'd0);
    chk("rst_errs", {30'd0, addr_err, bus_err}, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    access(1, 0, 2'b10, 32'h0000_0104, 32'hDEAD_BEEF, 0, 1, 32'h0);
    access(0, 1, 2'b00, 32'h0000_0203, 32'h0, 1, 0, 32'h80FF_1234);
    access(0, 1, 2'b00, 32'h0000_0203, 32'h0, 0, 0, 32'h80FF_1234);
    access(1, 0, 2'b01, 32'h0000_0002, 32'h0000_ABCD, 0, 2, 32'h0);
    access(0, 1, 2'b01, 32'h0000_0002, 32'h0, 0, 0, 32'h5678_0000);
    access(0, 1, 2'b10, 32'h0000_0006, 32'h0, 0, 0, 32'h0);
    access(0, 1, 2'b10, 32'h0000_0010, 32'h0, 0, TO, 32'h1234_5678);
    access(0, 1, 2'b10, 32'h0000_0014, 32'h0, 0, 1000, 32'h0);
    access(1, 1, 2'b00, 32'h0000_0021, 32'h0000_005A, 0, 0, 32'hFFFF_FFFF);

    // Reset while a load is waiting on the bus.
    begin
      bus_t b;
      resp_t p;
      b.addr = 32'h40; b.be = 4'hF; b.we = 1'b0; b.wdata = '0;
      bus_q.push_back(b);
      p.lat = 1000; p.rdata = '0;
      resp_q.push_back(p);
      memreadM = 1'b1; sizeM = 2'b10; aluoutM = 32'h40;
      repeat (3) begin @(posedge clk); #1; end
      memreadM = 1'b0;
      rst = 1'b0;
      #1;
      chk("abort_mem_req", 32'(bif.mem_req), 32'd0);
      chk("abort_stallM", 32'(stallM), 32'd0);
      chk("abort_readdataM", readdataM, 32'd0);
      bus_q.delete();
      resp_q.delete();
      model_rd = '0;
      @(posedge clk); @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
    end
    access(0, 1, 2'b10, 32'h0000_0080, 32'h0, 0, 1, 32'hCAFE_F00D);

    for (int i = 0; i < 250; i++) begin
      logic we, rd;
      int   sel, lat;
      we = 1'($urandom);
      rd = !we || ($urandom % 4 == 0);
      sel = $urandom % 10;
      if (sel < 6) lat = $urandom % 3;
      else if (sel == 6) lat = TO;
      else if (sel == 7) lat = TO + 1;
      else lat = $urandom % 6;
      access(we, rd, 2'($urandom), $urandom, $urandom, 1'($urandom), lat, $urandom);
      repeat ($urandom % 3) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("res_q_drained", 32'(res_q.size()), 32'd0);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
